// File: rtl/rv32i_types.sv
// Shared RV32I front-end types.
// Defines the 32-bit machine word, the canonical NOP encoding
// (addi x0, x0, 0) and the packed {pc, ir} record held by the IF/ID buffer.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // addi x0, x0, 0: what decode sees whenever the buffer is empty
    localparam rv32i_word NOP_INSTR = 32'h00000013;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word ir;
    } if_id_entry_t;

    // Even parity over one entry. Not used inside the buffer itself; it lets
    // a future storage-protection wrapper share one definition with this file.
    function automatic logic entry_parity(input if_id_entry_t e);
        return ^{e.pc, e.ir};
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer.
// A circular FIFO of DEPTH {pc, ir} entries that sits between fetch and
// decode. The head entry is presented combinationally to decode; anything
// pushed at an edge becomes visible only after that edge.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset, highest priority
//   flush      - drop every held entry and ignore this cycle's push/pop
//   IF_valid   - fetch presents an instruction this cycle
//   IF_pc_out  - PC of the presented instruction
//   IF_ir_out  - presented instruction word
//   IF_ready   - buffer can accept a push (not full)
//   ID_ready   - decode consumes the head entry this cycle
//   ID_valid   - head entry is valid (not empty)
//   ID_pc      - PC of head entry (0 when empty)
//   ID_ir      - instruction of head entry (NOP when empty)
//   count      - number of occupied entries
module if_id_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       IF_valid,
    input  rv32i_word                  IF_pc_out,
    input  rv32i_word                  IF_ir_out,
    output logic                       IF_ready,
    input  logic                       ID_ready,
    output logic                       ID_valid,
    output rv32i_word                  ID_pc,
    output rv32i_word                  ID_ir,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    if_id_entry_t          entries_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  not_empty_s;
    logic                  not_full_s;

    // Occupancy flags; IF_ready deliberately ignores ID_ready so a full
    // buffer never accepts a push even while it is being popped.
    always_comb begin
        not_empty_s = (count_r != {CNT_W{1'b0}});
        not_full_s  = (count_r < DEPTH_C);
        push_s      = IF_valid && not_full_s && !flush;
        pop_s       = not_empty_s && ID_ready && !flush;
    end

    // Entry storage: written on push only, never cleared (pointers and count
    // alone decide what is visible).
    always_ff @(posedge clk) begin
        if (push_s) begin
            entries_r[wr_ptr_r] <= '{pc: IF_pc_out, ir: IF_ir_out};
        end
    end

    // Pointer and occupancy state. DEPTH is a power of two, so the pointers
    // wrap modulo DEPTH by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; an empty buffer shows PC 0 and a NOP so decode
    // never sees stale storage.
    always_comb begin
        IF_ready = not_full_s;
        ID_valid = not_empty_s;
        count    = count_r;
        if (not_empty_s) begin
            ID_pc = entries_r[rd_ptr_r].pc;
            ID_ir = entries_r[rd_ptr_r].ir;
        end else begin
            ID_pc = 32'h0000_0000;
            ID_ir = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready;
    logic [31:0] if_pc, if_ir;

    logic        ifr2, idv2, ifr4, idv4;
    logic [31:0] idpc2, idir2, idpc4, idir4;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .IF_valid(if_valid),
        .IF_pc_out(if_pc), .IF_ir_out(if_ir), .IF_ready(ifr2),
        .ID_ready(id_ready), .ID_valid(idv2), .ID_pc(idpc2), .ID_ir(idir2),
        .count(cnt2)
    );

    if_id_buffer #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .IF_valid(if_valid),
        .IF_pc_out(if_pc), .IF_ir_out(if_ir), .IF_ready(ifr4),
        .ID_ready(id_ready), .ID_valid(idv4), .ID_pc(idpc4), .ID_ir(idir4),
        .count(cnt4)
    );

    typedef struct {
        logic        rst, flush, v;
        logic [31:0] pc, ir;
        logic        rdy;
        logic        e_valid, e_ready;
        logic [31:0] e_pc, e_ir;
        int          e_cnt;
    } vec_t;

    vec_t vecs [19];

    if_id_entry_t q [2][$];
    int dep [2] = '{2, 4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] pc, input logic [31:0] ir, input logic rd);
        rst = r; flush = f; if_valid = v; if_pc = pc; if_ir = ir; id_ready = rd;
        @(posedge clk);
        #1;
    endtask

    // Queue-level reference: pop the front, append the push, all decided
    // from the state before the edge.
    task automatic model_edge(input logic r, input logic f, input logic v,
                              input logic [31:0] pc, input logic [31:0] ir, input logic rd);
        for (int j = 0; j < 2; j++) begin
            int  sz;
            bit  can_push, can_pop;
            sz = q[j].size();
            can_push = v && (sz < dep[j]);
            can_pop  = rd && (sz != 0);
            if (r || f) begin
                q[j].delete();
            end else begin
                if (can_pop) void'(q[j].pop_front());
                if (can_push) q[j].push_back('{pc: pc, ir: ir});
            end
        end
    endtask

    task automatic check_model(input int j, input string tag);
        int sz;
        logic [31:0] e_pc, e_ir;
        sz = q[j].size();
        e_pc = (sz != 0) ? q[j][0].pc : 32'h0;
        e_ir = (sz != 0) ? q[j][0].ir : 32'h00000013;
        if (j == 0) begin
            chk({tag, " valid"}, {31'd0, idv2}, {31'd0, sz != 0});
            chk({tag, " ready"}, {31'd0, ifr2}, {31'd0, sz < dep[j]});
            chk({tag, " pc"}, idpc2, e_pc);
            chk({tag, " ir"}, idir2, e_ir);
            chk({tag, " count"}, {30'd0, cnt2}, sz);
        end else begin
            chk({tag, " valid"}, {31'd0, idv4}, {31'd0, sz != 0});
            chk({tag, " ready"}, {31'd0, ifr4}, {31'd0, sz < dep[j]});
            chk({tag, " pc"}, idpc4, e_pc);
            chk({tag, " ir"}, idir4, e_ir);
            chk({tag, " count"}, {29'd0, cnt4}, sz);
        end
    endtask

    initial begin
        // rst flush v pc ir rdy | valid ready pc ir count   (DEPTH=2 instance)
        vecs[0]  = '{1,0,0,32'h0,  32'h0,        0, 0,1,32'h0,  32'h00000013,0}; // reset
        vecs[1]  = '{0,0,0,32'h0,  32'h0,        0, 0,1,32'h0,  32'h00000013,0}; // idle
        vecs[2]  = '{0,0,1,32'h60, 32'h00500093, 0, 1,1,32'h60, 32'h00500093,1};
        vecs[3]  = '{0,0,1,32'h64, 32'h00A00113, 0, 1,0,32'h60, 32'h00500093,2};
        vecs[4]  = '{0,0,1,32'h68, 32'h00F00193, 0, 1,0,32'h60, 32'h00500093,2}; // dropped
        vecs[5]  = '{0,0,0,32'h0,  32'h0,        1, 1,1,32'h64, 32'h00A00113,1};
        vecs[6]  = '{0,0,0,32'h0,  32'h0,        1, 0,1,32'h0,  32'h00000013,0};
        vecs[7]  = '{0,0,0,32'h0,  32'h0,        1, 0,1,32'h0,  32'h00000013,0}; // no underflow
        vecs[8]  = '{0,0,1,32'h70, 32'h11,       0, 1,1,32'h70, 32'h11,      1};
        vecs[9]  = '{0,0,1,32'h74, 32'h22,       0, 1,0,32'h70, 32'h11,      2};
        vecs[10] = '{0,1,1,32'h78, 32'h99,       1, 0,1,32'h0,  32'h00000013,0}; // flush
        vecs[11] = '{0,0,1,32'h80, 32'h33,       0, 1,1,32'h80, 32'h33,      1};
        vecs[12] = '{0,0,1,32'h84, 32'h44,       0, 1,0,32'h80, 32'h33,      2};
        vecs[13] = '{1,0,1,32'h88, 32'h55,       0, 0,1,32'h0,  32'h00000013,0}; // rst+push
        vecs[14] = '{0,0,0,32'h0,  32'h0,        0, 0,1,32'h0,  32'h00000013,0};
        vecs[15] = '{0,0,1,32'h90, 32'h66,       0, 1,1,32'h90, 32'h66,      1};
        vecs[16] = '{0,0,1,32'h94, 32'h77,       0, 1,0,32'h90, 32'h66,      2};
        vecs[17] = '{0,0,1,32'h98, 32'h88,       1, 1,1,32'h94, 32'h77,      1}; // full: pop only
        vecs[18] = '{0,0,0,32'h0,  32'h0,        1, 0,1,32'h0,  32'h00000013,0};

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = 32'h0; if_ir = 32'h0;
        #1;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].flush, vecs[i].v, vecs[i].pc, vecs[i].ir, vecs[i].rdy);
            chk($sformatf("vec%0d valid", i), {31'd0, idv2}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d ready", i), {31'd0, ifr2}, {31'd0, vecs[i].e_ready});
            chk($sformatf("vec%0d pc", i), idpc2, vecs[i].e_pc);
            chk($sformatf("vec%0d ir", i), idir2, vecs[i].e_ir);
            chk($sformatf("vec%0d count", i), {30'd0, cnt2}, vecs[i].e_cnt);
        end

        // Steady push+pop at count=1 across pointer wraps.
        step(1'b0, 1'b0, 1'b1, 32'h100, 32'hA000_0000, 1'b0);
        chk("stream prime count", {30'd0, cnt2}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b1);
            chk($sformatf("stream%0d count", k), {30'd0, cnt2}, 32'd1);
            chk($sformatf("stream%0d pc", k), idpc2, 32'h100 + 32'(4 * k));
            chk($sformatf("stream%0d ir", k), idir2, 32'hA000_0000 + 32'(k));
        end

        // Randomized run against the queue model on both depths.
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int j = 0; j < 2; j++) q[j].delete();
        for (int n = 0; n < 400; n++) begin
            logic r, f, v, rd;
            logic [31:0] pc, ir;
            r  = ($urandom_range(0, 59) == 0);
            f  = ($urandom_range(0, 24) == 0);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            pc = $urandom;
            ir = $urandom;
            step(r, f, v, pc, ir, rd);
            model_edge(r, f, v, pc, ir, rd);
            check_model(0, $sformatf("rnd%0d d2", n));
            check_model(1, $sformatf("rnd%0d d4", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
